// File: rtl/pm_line_fill.sv
// ---------------------------------------------------------------------------
// pm_line_fill
//
// Single-line instruction cache with its ROM fill controller. The cache sits
// between the program ROM and the fetch stage. It holds one line of
// 2^OFFSET_W words, tagged by the upper address bits.
//
// On a hit, the instruction is returned combinationally and hold stays low.
// On a miss, hold is raised to stall the core. The line is then streamed in
// from the ROM, one address per cycle, and the core is released afterwards.
//
// Ports
//   clk             system clock; all state changes on the rising edge
//   reset           asynchronous, active-low reset
//   pm_address      fetch address from the program counter
//   flush           single-cycle pulse that invalidates the line
//   rom_data        ROM read data, ROM_LAT cycles after rom_address
//   rom_address     ROM read address (holds its last value outside a fill)
//   pm_data         instruction to IR; valid while hold is low
//   hold            stall request to the core
//   start_hold      1-cycle pulse when a miss is detected
//   end_hold        1-cycle pulse when a fill completes
//   hold_count      number of completed fills, saturating at 7
//   cache_wren      line-array write enable (debug tap)
//   cache_wroffset  line-array write offset (debug tap)
//   cache_rdoffset  line-array read offset = pm_address offset bits
// ---------------------------------------------------------------------------
module pm_line_fill #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 5,
  parameter int ROM_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   pm_address,
  input  logic                flush,
  input  logic [DATA_W-1:0]   rom_data,
  output logic [ADDR_W-1:0]   rom_address,
  output logic [DATA_W-1:0]   pm_data,
  output logic                hold,
  output logic                start_hold,
  output logic                end_hold,
  output logic [2:0]          hold_count,
  output logic                cache_wren,
  output logic [OFFSET_W-1:0] cache_wroffset,
  output logic [OFFSET_W-1:0] cache_rdoffset
);

  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int LINE  = 2 ** OFFSET_W;
  // Wide enough for the last FILL cycle index, LINE + ROM_LAT - 1.
  localparam int CNT_W = OFFSET_W + 2;

  localparam logic [CNT_W-1:0] C_LINE = CNT_W'(LINE);
  localparam logic [CNT_W-1:0] C_LAT  = CNT_W'(ROM_LAT);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LINE + ROM_LAT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic              r_valid;
  logic [TAG_W-1:0]  r_tag;
  logic [CNT_W-1:0]  r_cnt;        // cycle index within FILL
  logic              r_flush_pend;
  logic [2:0]        r_hold_count;
  logic [ADDR_W-1:0] r_rom_addr;   // last address presented to the ROM
  logic [DATA_W-1:0] r_line [0:LINE-1];

  logic                w_idle;
  logic                w_fill;
  logic                w_done;
  logic                w_hit;
  logic                w_issue;
  logic                w_wren;
  logic [OFFSET_W-1:0] w_wr_off;
  logic [ADDR_W-1:0]   w_rom_addr;

  assign w_idle = (r_state == S_IDLE);
  assign w_fill = (r_state == S_FILL);
  assign w_done = (r_state == S_DONE);
  assign w_hit  = r_valid & (r_tag == pm_address[ADDR_W-1:OFFSET_W]);

  // The first LINE cycles of FILL issue reads.
  // Writes start ROM_LAT cycles later, trailing the issue counter by ROM_LAT.
  assign w_issue    = w_fill & (r_cnt < C_LINE);
  assign w_wren     = w_fill & (r_cnt >= C_LAT);
  assign w_wr_off   = OFFSET_W'(r_cnt - C_LAT);
  assign w_rom_addr = w_issue ? {r_tag, r_cnt[OFFSET_W-1:0]} : r_rom_addr;

  assign rom_address    = w_rom_addr;
  assign hold           = ~(w_idle & w_hit);
  // Gated by reset so the pulse stays low while the block is held in reset,
  // even though the reset state itself looks like a cold miss.
  assign start_hold     = reset & w_idle & ~w_hit;
  assign end_hold       = w_done;
  assign hold_count     = r_hold_count;
  assign cache_wren     = w_wren;
  assign cache_wroffset = w_wren ? w_wr_off : '0;
  assign cache_rdoffset = pm_address[OFFSET_W-1:0];
  assign pm_data        = (w_idle & w_hit) ? r_line[pm_address[OFFSET_W-1:0]] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_tag        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_hold_count <= 3'd0;
      r_rom_addr   <= '0;
    end else begin
      r_rom_addr <= w_rom_addr;
      case (r_state)
        S_IDLE: begin
          // A flush takes effect at this edge, so a fetch in the same
          // cycle still sees the pre-flush hit.
          if (flush) begin
            r_valid <= 1'b0;
          end
          if (!w_hit) begin
            r_tag   <= pm_address[ADDR_W-1:OFFSET_W];
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (flush) begin
            r_flush_pend <= 1'b1;
          end
          if (r_cnt == C_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          // A flush seen at any point during the fill, including this
          // cycle, leaves the new line invalid and forces a refill.
          r_valid      <= ~(r_flush_pend | flush);
          r_flush_pend <= 1'b0;
          if (r_hold_count != 3'd7) begin
            r_hold_count <= r_hold_count + 3'd1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The line array is not reset.
  // A line that was only partly written is never marked valid.
  always_ff @(posedge clk) begin
    if (w_wren) begin
      r_line[w_wr_off] <= rom_data;
    end
  end

endmodule

// File: tb/tb_pm_line_fill.sv
// ---------------------------------------------------------------------------
// tb_pm_line_fill
//
// Drives two instances of pm_line_fill, one with ROM_LAT=1 and one with
// ROM_LAT=3. Each instance has its own ROM model, ROM[a] = a ^ 0x5A.
//
// A behavioural model of the cache (valid/tag/line state plus fill progress)
// predicts every output. A single negedge process compares the outputs
// against it on every cycle. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_pm_line_fill;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   [2];
  logic [7:0] pm_a    [2];
  logic       flush_i [2];
  logic [7:0] rom_d   [2];
  logic [7:0] rom_a   [2];
  logic [7:0] pm_d    [2];
  logic       hold_o  [2];
  logic       sh_o    [2];
  logic       eh_o    [2];
  logic [2:0] hc_o    [2];
  logic       wren_o  [2];
  logic [4:0] wro_o   [2];
  logic [4:0] rdo_o   [2];
  logic [7:0] pipe    [2][3];

  int errors = 0;
  int checks = 0;

  pm_line_fill #(.ADDR_W(8), .DATA_W(8), .OFFSET_W(5), .ROM_LAT(LAT0)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .pm_address(pm_a[0]), .flush(flush_i[0]),
    .rom_data(rom_d[0]), .rom_address(rom_a[0]), .pm_data(pm_d[0]),
    .hold(hold_o[0]), .start_hold(sh_o[0]), .end_hold(eh_o[0]),
    .hold_count(hc_o[0]), .cache_wren(wren_o[0]), .cache_wroffset(wro_o[0]),
    .cache_rdoffset(rdo_o[0])
  );

  pm_line_fill #(.ADDR_W(8), .DATA_W(8), .OFFSET_W(5), .ROM_LAT(LAT1)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .pm_address(pm_a[1]), .flush(flush_i[1]),
    .rom_data(rom_d[1]), .rom_address(rom_a[1]), .pm_data(pm_d[1]),
    .hold(hold_o[1]), .start_hold(sh_o[1]), .end_hold(eh_o[1]),
    .hold_count(hc_o[1]), .cache_wren(wren_o[1]), .cache_wroffset(wro_o[1]),
    .cache_rdoffset(rdo_o[1])
  );

  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  // ROM: data appears ROM_LAT rising edges after its address.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pipe[d][0] <= rom_fn(rom_a[d]);
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end
  assign rom_d[0] = pipe[0][LAT0-1];
  assign rom_d[1] = pipe[1][LAT1-1];

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got 0x%0h expected 0x%0h", name, d, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       m_valid   [2];
  logic       m_filling [2];
  logic       m_done    [2];
  logic       m_pend    [2];
  logic [2:0] m_tag     [2];
  logic [2:0] m_cnt     [2];
  int         m_k       [2];   // cycles spent in the current fill
  logic [7:0] m_last    [2];   // last ROM address presented

  function automatic logic e_idle(input int d);
    return !m_filling[d] && !m_done[d];
  endfunction

  function automatic logic e_hit(input int d);
    return m_valid[d] && (m_tag[d] == pm_a[d][7:5]);
  endfunction

  function automatic logic [7:0] e_rom(input int d);
    if (m_filling[d] && m_k[d] < 32) return {m_tag[d], 5'(m_k[d])};
    return m_last[d];
  endfunction

  function automatic logic e_wren(input int d);
    return m_filling[d] && (m_k[d] >= lat_of(d));
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        m_valid[d]   <= 1'b0;
        m_filling[d] <= 1'b0;
        m_done[d]    <= 1'b0;
        m_pend[d]    <= 1'b0;
        m_tag[d]     <= 3'd0;
        m_cnt[d]     <= 3'd0;
        m_k[d]       <= 0;
        m_last[d]    <= 8'h00;
      end else begin
        m_last[d] <= e_rom(d);
        if (e_idle(d)) begin
          if (flush_i[d]) m_valid[d] <= 1'b0;
          if (!e_hit(d)) begin
            m_tag[d]     <= pm_a[d][7:5];
            m_valid[d]   <= 1'b0;
            m_filling[d] <= 1'b1;
            m_k[d]       <= 0;
          end
        end else if (m_filling[d]) begin
          if (flush_i[d]) m_pend[d] <= 1'b1;
          if (m_k[d] == 31 + lat_of(d)) begin
            m_filling[d] <= 1'b0;
            m_done[d]    <= 1'b1;
          end else begin
            m_k[d] <= m_k[d] + 1;
          end
        end else begin
          m_valid[d] <= !(m_pend[d] || flush_i[d]);
          m_pend[d]  <= 1'b0;
          if (m_cnt[d] != 3'd7) m_cnt[d] <= 3'(m_cnt[d] + 3'd1);
          m_done[d]  <= 1'b0;
        end
      end
    end
  end

  // Compare DUT outputs against the model on every cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        chk("rst_hold", d, hold_o[d], 1);
        chk("rst_start_hold", d, sh_o[d], 0);
        chk("rst_end_hold", d, eh_o[d], 0);
        chk("rst_hold_count", d, hc_o[d], 0);
        chk("rst_wren", d, wren_o[d], 0);
        chk("rst_wroffset", d, wro_o[d], 0);
        chk("rst_rom_address", d, rom_a[d], 0);
        chk("rst_pm_data", d, pm_d[d], 0);
      end else begin
        chk("hold", d, hold_o[d], !(e_idle(d) && e_hit(d)));
        chk("start_hold", d, sh_o[d], e_idle(d) && !e_hit(d));
        chk("end_hold", d, eh_o[d], m_done[d]);
        chk("hold_count", d, hc_o[d], m_cnt[d]);
        chk("cache_wren", d, wren_o[d], e_wren(d));
        chk("cache_wroffset", d, wro_o[d], e_wren(d) ? 5'(m_k[d] - lat_of(d)) : 5'd0);
        chk("cache_rdoffset", d, rdo_o[d], pm_a[d][4:0]);
        chk("rom_address", d, rom_a[d], e_rom(d));
        if (e_idle(d) && e_hit(d))
          chk("pm_data", d, pm_d[d], rom_fn({m_tag[d], pm_a[d][4:0]}));
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call at the negedge of the IDLE cycle showing start_hold.
  // This task returns at the negedge of the DONE cycle.
  task automatic run_fill(input int d, input logic [2:0] tg, input int exp_len);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (n < 32) chk("fill_rom_address", d, rom_a[d], {tg, 5'(n)});
      if (n == lat_of(d) - 1) chk("write_before_latency", d, wren_o[d], 0);
      if (n == lat_of(d)) chk("first_write", d, {wren_o[d], wro_o[d]}, {1'b1, 5'd0});
      if (eh_o[d]) seen = 1;
      else n++;
    end
    chk("fill_length", d, n, exp_len);
  endtask

  task automatic wait_end(input int d);
    int n;
    n = 0;
    while (!eh_o[d] && n < 100) begin
      @(negedge clk);
      if (!eh_o[d]) n++;
    end
    chk("wait_end_hold", d, eh_o[d], 1);
  endtask

  initial begin
    logic [7:0] bases [3];
    bases = '{8'h60, 8'h80, 8'hE0};
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    pm_a[0] = 8'h00; pm_a[1] = 8'h00;
    flush_i[0] = 1'b0; flush_i[1] = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", 0, hold_o[0], 1);
    chk("reset_pm_data", 0, pm_d[0], 8'h00);

    // Cold start
    step(); rst_n[0] = 1'b1;
    @(negedge clk);
    chk("cold_start_hold", 0, sh_o[0], 1);
    run_fill(0, 3'd0, 33);
    @(negedge clk);
    chk("cold_hold", 0, hold_o[0], 0);
    chk("cold_pm_data", 0, pm_d[0], 8'h5A);
    chk("cold_hold_count", 0, hc_o[0], 1);
    $display("cold start fill done at t=%0t", $time);

    // Hits across the whole line
    for (int a = 0; a < 32; a++) begin
      step(); pm_a[0] = 8'(a);
      @(negedge clk);
      chk("hit_hold", 0, hold_o[0], 0);
    end
    chk("hit_last_word", 0, pm_d[0], 8'h45);

    // Miss to the next line
    step(); pm_a[0] = 8'h20;
    @(negedge clk);
    chk("miss_start_hold", 0, sh_o[0], 1);
    run_fill(0, 3'd1, 33);
    @(negedge clk);
    chk("miss_pm_data", 0, pm_d[0], 8'h7A);
    $display("miss 0x20 fill done at t=%0t", $time);

    // Flush in IDLE
    step(); flush_i[0] = 1'b1;
    @(negedge clk);
    chk("flush_same_cycle_hit", 0, hold_o[0], 0);
    step(); flush_i[0] = 1'b0;
    @(negedge clk);
    chk("flush_idle_rehold", 0, hold_o[0], 1);
    chk("flush_idle_start", 0, sh_o[0], 1);
    run_fill(0, 3'd1, 33);
    @(negedge clk);
    chk("flush_idle_count", 0, hc_o[0], 3);
    $display("idle flush refill done at t=%0t", $time);

    // Flush during FILL
    step(); pm_a[0] = 8'h40;
    @(negedge clk);
    chk("miss40_start", 0, sh_o[0], 1);
    repeat (5) step();
    flush_i[0] = 1'b1;
    step(); flush_i[0] = 1'b0;
    wait_end(0);
    @(negedge clk);
    chk("flush_fill_refill", 0, sh_o[0], 1);
    run_fill(0, 3'd2, 33);
    @(negedge clk);
    chk("flush_fill_pm_data", 0, pm_d[0], 8'h1A);
    chk("flush_fill_count", 0, hc_o[0], 5);
    $display("mid-fill flush refill done at t=%0t", $time);

    // Further misses until the counter saturates; the last one uses tag 7
    for (int b = 0; b < 3; b++) begin
      step(); pm_a[0] = bases[b];
      @(negedge clk);
      run_fill(0, bases[b][7:5], 33);
      @(negedge clk);
      $display("miss 0x%0h fill done at t=%0t", bases[b], $time);
    end
    chk("saturated_count", 0, hc_o[0], 7);
    step(); pm_a[0] = 8'hFF;
    @(negedge clk);
    chk("tag7_top_word", 0, pm_d[0], 8'hA5);

    // Reset during FILL cycle 10
    step(); pm_a[0] = 8'h20;
    @(negedge clk);
    chk("pre_reset_start", 0, sh_o[0], 1);
    repeat (11) @(posedge clk);
    #1 rst_n[0] = 1'b0;
    #1;
    chk("async_rst_hold", 0, hold_o[0], 1);
    chk("async_rst_rom_address", 0, rom_a[0], 8'h00);
    chk("async_rst_wren", 0, wren_o[0], 0);
    chk("async_rst_count", 0, hc_o[0], 0);
    step(); rst_n[0] = 1'b1;
    @(negedge clk);
    chk("post_reset_start", 0, sh_o[0], 1);
    run_fill(0, 3'd1, 33);
    @(negedge clk);
    chk("post_reset_pm_data", 0, pm_d[0], 8'h7A);
    chk("post_reset_count", 0, hc_o[0], 1);
    $display("post-reset refill done at t=%0t", $time);

    // Cold start with ROM_LAT=3
    step(); rst_n[1] = 1'b1;
    @(negedge clk);
    chk("lat3_start", 1, sh_o[1], 1);
    run_fill(1, 3'd0, 35);
    @(negedge clk);
    chk("lat3_hold", 1, hold_o[1], 0);
    chk("lat3_pm_data", 1, pm_d[1], 8'h5A);
    $display("latency-3 cold fill done at t=%0t", $time);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
